// File: rtl/encoder_move_ctrl_pkg.sv
// Shared FSM encoding and default tuning values for the axis position sequencer.
package encoder_move_ctrl_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_HOME_SEEK   = 3'd1;
    localparam logic [2:0] ST_HOME_SETTLE = 3'd2;
    localparam logic [2:0] ST_MOVE        = 3'd3;
    localparam logic [2:0] ST_SETTLE      = 3'd4;
    localparam logic [2:0] ST_FAULT       = 3'd5;

    localparam int DEF_DEADBAND      = 1;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_STALL_CYCLES  = 16;

    // SETTLE -> MOVE re-entries tolerated per command before declaring a fault
    localparam int MAX_REENTRIES = 3;

endpackage

// File: rtl/encoder_move_ctrl_if.sv
// Command, decoder and motor-pin bundle for one axis; slave = sequencer side.
interface encoder_move_ctrl_if #(
    parameter int width = 8
);
    logic [width-1:0] count;
    logic             home_sw;
    logic             cmd_home;
    logic             cmd_move;
    logic [width-1:0] target;
    logic             abort;
    logic             motor_en;
    logic             motor_dir;
    logic [width-1:0] position;
    logic             busy;
    logic             done;
    logic             homed;
    logic             fault;

    modport slave (
        input  count, home_sw, cmd_home, cmd_move, target, abort,
        output motor_en, motor_dir, position, busy, done, homed, fault
    );

    modport master (
        output count, home_sw, cmd_home, cmd_move, target, abort,
        input  motor_en, motor_dir, position, busy, done, homed, fault
    );
endinterface

// File: rtl/encoder_move_ctrl_stall_monitor.sv
// Flags a stalled axis: count unchanged for STALL_CYCLES clocks while driving.
// stall is asserted in the cycle whose clock edge brings the counter to STALL_CYCLES.
module stall_monitor
    import encoder_move_ctrl_pkg::*;
#(
    parameter int width        = 8,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] count,
    input  logic             motor_en,
    output logic             stall
);
    localparam int CW = $clog2(STALL_CYCLES + 1);

    logic [width-1:0] prev_count;
    logic [CW-1:0]    idle_cnt;
    logic             changed;

    assign changed = (count != prev_count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_count <= '0;
            idle_cnt   <= '0;
        end else begin
            prev_count <= count;
            if (changed || !motor_en)
                idle_cnt <= '0;
            else if (idle_cnt != CW'(STALL_CYCLES))
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign stall = motor_en && !changed && (idle_cnt >= CW'(STALL_CYCLES - 1));

endmodule

// File: rtl/encoder_move_ctrl.sv
// Single-axis sequencer: homes against a switch, then drives motor_en/motor_dir to a target.
// Decoder count is never cleared; position is count minus a latched software offset.
module encoder_move_ctrl
    import encoder_move_ctrl_pkg::*;
#(
    parameter int width         = 8,
    parameter int DEADBAND      = DEF_DEADBAND,
    parameter int STALL_CYCLES  = DEF_STALL_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder_move_ctrl_if.slave bus
);
    localparam int              SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]      RETRY_MAX   = 2'(MAX_REENTRIES);
    localparam logic [width:0]  BAND        = (width + 1)'(DEADBAND);

    logic [2:0]       state, state_n;
    logic             sw_meta, sw_sync;
    logic [width-1:0] home_offset, offset_n;
    logic [width-1:0] target_q, target_n;
    logic [width-1:0] position;
    logic [SW-1:0]    settle_cnt, settle_n;
    logic [1:0]       retry, retry_n;
    logic             motor_en, motor_dir, done, busy, homed, fault;
    logic             en_n, dir_n, done_n, homed_n, fault_n;
    logic             stall;

    logic [width-1:0] d_move, d_cmd;
    logic             band_move, band_cmd, up_move, up_cmd;

    // |d| needs one extra bit so the most negative distance does not alias to itself
    function automatic logic [width:0] magnitude(input logic [width-1:0] d);
        logic [width:0] e;
        e = {d[width-1], d};
        return e[width] ? -e : e;
    endfunction

    assign position  = bus.count - home_offset;
    assign d_move    = target_q - position;
    assign d_cmd     = bus.target - position;
    assign band_move = (magnitude(d_move) <= BAND);
    assign band_cmd  = (magnitude(d_cmd) <= BAND);
    assign up_move   = !d_move[width-1] && (d_move != '0);
    assign up_cmd    = !d_cmd[width-1] && (d_cmd != '0);

    stall_monitor #(
        .width        (width),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .count    (bus.count),
        .motor_en (motor_en),
        .stall    (stall)
    );

    always_comb begin
        state_n  = state;
        en_n     = 1'b0;
        dir_n    = motor_dir;
        done_n   = 1'b0;
        homed_n  = homed;
        fault_n  = fault;
        offset_n = home_offset;
        target_n = target_q;
        settle_n = '0;
        retry_n  = retry;

        if (bus.abort) begin
            state_n = ST_IDLE;
        end else if (stall) begin
            state_n = ST_FAULT;
            fault_n = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_FAULT: begin
                    if (bus.cmd_home) begin
                        state_n = ST_HOME_SEEK;
                        en_n    = 1'b1;
                        dir_n   = 1'b0;
                        fault_n = 1'b0;
                    end else if (bus.cmd_move) begin
                        if (homed) begin
                            target_n = bus.target;
                            fault_n  = 1'b0;
                            retry_n  = '0;
                            if (band_cmd) begin
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
                            end else begin
                                state_n = ST_MOVE;
                                en_n    = 1'b1;
                                dir_n   = up_cmd;
                            end
                        end else begin
                            state_n = ST_FAULT;
                            fault_n = 1'b1;
                        end
                    end
                end
                ST_HOME_SEEK: begin
                    dir_n = 1'b0;
                    if (sw_sync) state_n = ST_HOME_SETTLE;
                    else         en_n    = 1'b1;
                end
                ST_HOME_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        offset_n = bus.count;
                        homed_n  = 1'b1;
                        done_n   = 1'b1;
                        state_n  = ST_IDLE;
                    end else begin
                        settle_n = settle_cnt + SW'(1);
                    end
                end
                ST_MOVE: begin
                    if (band_move) begin
                        state_n = ST_SETTLE;
                    end else begin
                        en_n  = 1'b1;
                        dir_n = up_move;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_n = settle_cnt + SW'(1);
                    end else if (band_move) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (retry == RETRY_MAX) begin
                        fault_n = 1'b1;
                        state_n = ST_FAULT;
                    end else begin
                        retry_n = retry + 2'd1;
                        state_n = ST_MOVE;
                        en_n    = 1'b1;
                        dir_n   = up_move;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sw_meta     <= 1'b0;
            sw_sync     <= 1'b0;
            home_offset <= '0;
            target_q    <= '0;
            settle_cnt  <= '0;
            retry       <= '0;
            motor_en    <= 1'b0;
            motor_dir   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            homed       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            sw_meta     <= bus.home_sw;
            sw_sync     <= sw_meta;
            state       <= state_n;
            home_offset <= offset_n;
            target_q    <= target_n;
            settle_cnt  <= settle_n;
            retry       <= retry_n;
            motor_en    <= en_n;
            motor_dir   <= dir_n;
            done        <= done_n;
            busy        <= (state_n != ST_IDLE) && (state_n != ST_FAULT);
            homed       <= homed_n;
            fault       <= fault_n;
        end
    end

    assign bus.position  = position;
    assign bus.motor_en  = motor_en;
    assign bus.motor_dir = motor_dir;
    assign bus.done      = done;
    assign bus.busy      = busy;
    assign bus.homed     = homed;
    assign bus.fault     = fault;

endmodule

// File: tb/tb_encoder_move_ctrl.sv
// Directed bench for encoder_move_ctrl; flags = {motor_en, busy, done, homed, fault}.
module tb_encoder_move_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [4:0] flags;

    encoder_move_ctrl_if #(.width(8)) bus();

    encoder_move_ctrl #(.width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign flags = {bus.motor_en, bus.busy, bus.done, bus.homed, bus.fault};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic home_at(input logic [7:0] c, output bit ok);
        ok = 1'b0;
        bus.count    = c;
        bus.home_sw  = 1'b1;
        bus.cmd_home = 1'b1;
        tick;
        bus.cmd_home = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", flags); end
        n_checks++;
        if (bus.motor_dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b want 0", bus.motor_dir); end
        n_checks++;
        if (bus.position !== 8'd37) begin n_fail++; $display("FAIL reset_position: got %0d want 37", bus.position); end
    endtask

    task automatic test_homing;
        bus.cmd_home = 1'b1;
        tick;
        bus.cmd_home = 1'b0;
        n_checks++;
        if (flags !== 5'b11000 || bus.motor_dir !== 1'b0) begin
            n_fail++; $display("FAIL home_seek_start: got %b dir %b want 11000 dir 0", flags, bus.motor_dir);
        end
        repeat (9) tick;
        n_checks++;
        if (flags !== 5'b11000) begin n_fail++; $display("FAIL home_seek_hold: got %b want 11000", flags); end
        bus.home_sw = 1'b1;
        repeat (2) tick;
        n_checks++;
        if (flags !== 5'b11000) begin n_fail++; $display("FAIL home_sync_delay: got %b want 11000", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b01000) begin n_fail++; $display("FAIL home_motor_off: got %b want 01000", flags); end
        repeat (3) tick;
        n_checks++;
        if (flags !== 5'b01000) begin n_fail++; $display("FAIL home_settle_early: got %b want 01000", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b00110) begin n_fail++; $display("FAIL home_done: got %b want 00110", flags); end
        n_checks++;
        if (bus.position !== 8'd0) begin n_fail++; $display("FAIL home_position: got %0d want 0", bus.position); end
        tick;
        n_checks++;
        if (flags !== 5'b00010) begin n_fail++; $display("FAIL home_done_pulse: got %b want 00010", flags); end
        bus.count = 8'd40;
        #1;
        n_checks++;
        if (bus.position !== 8'd3) begin n_fail++; $display("FAIL home_offset: got %0d want 3", bus.position); end
        bus.count = 8'd37;
    endtask

    task automatic test_move_up;
        bit run_ok;
        run_ok = 1'b1;
        bus.target   = 8'd20;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b11010 || bus.motor_dir !== 1'b1) begin
            n_fail++; $display("FAIL move_up_start: got %b dir %b want 11010 dir 1", flags, bus.motor_dir);
        end
        for (int i = 0; i < 19; i++) begin
            repeat (4) tick;
            if (bus.motor_en !== 1'b1 || bus.motor_dir !== 1'b1) run_ok = 1'b0;
            bus.count = bus.count + 8'd1;
        end
        n_checks++;
        if (run_ok !== 1'b1) begin n_fail++; $display("FAIL move_up_run: got motor stop/dir loss, want driving up"); end
        tick;
        n_checks++;
        if (flags !== 5'b01010 || bus.position !== 8'd19) begin
            n_fail++; $display("FAIL move_up_stop: got %b pos %0d want 01010 pos 19", flags, bus.position);
        end
        repeat (3) tick;
        n_checks++;
        if (flags !== 5'b01010) begin n_fail++; $display("FAIL move_up_settle: got %b want 01010", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b00110) begin n_fail++; $display("FAIL move_up_done: got %b want 00110", flags); end
    endtask

    task automatic test_wrap;
        bit ok;
        home_at(8'd0, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_home: got no done within budget, want done"); end
        bus.count    = 8'd250;
        bus.target   = 8'd5;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b11010 || bus.motor_dir !== 1'b1) begin
            n_fail++; $display("FAIL wrap_start: got %b dir %b want 11010 dir 1", flags, bus.motor_dir);
        end
        for (int i = 0; i < 10; i++) begin
            repeat (2) tick;
            bus.count = bus.count + 8'd1;
        end
        n_checks++;
        if (flags !== 5'b11010) begin n_fail++; $display("FAIL wrap_running: got %b want 11010", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b01010 || bus.position !== 8'd4) begin
            n_fail++; $display("FAIL wrap_stop: got %b pos %0d want 01010 pos 4", flags, bus.position);
        end
        repeat (4) tick;
        n_checks++;
        if (flags !== 5'b00110) begin n_fail++; $display("FAIL wrap_done: got %b want 00110", flags); end
    endtask

    task automatic test_stall;
        bus.target   = 8'd100;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b11010) begin n_fail++; $display("FAIL stall_start: got %b want 11010", flags); end
        repeat (15) tick;
        n_checks++;
        if (flags !== 5'b11010) begin n_fail++; $display("FAIL stall_early: got %b want 11010", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b00011) begin n_fail++; $display("FAIL stall_fault: got %b want 00011", flags); end
        bus.target   = 8'd5;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b00110) begin n_fail++; $display("FAIL stall_clear: got %b want 00110", flags); end
    endtask

    task automatic test_unhomed_abort;
        bit ok;
        bit en_seen;
        en_seen = 1'b0;
        bus.target   = 8'd50;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b11010) begin n_fail++; $display("FAIL pre_reset_move: got %b want 11010", flags); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_checks++;
        if (flags !== 5'b00000) begin n_fail++; $display("FAIL midop_reset: got %b want 00000", flags); end
        bus.target   = 8'd10;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        if (bus.motor_en !== 1'b0) en_seen = 1'b1;
        n_checks++;
        if (flags !== 5'b00001) begin n_fail++; $display("FAIL unhomed_fault: got %b want 00001", flags); end
        repeat (3) begin
            tick;
            if (bus.motor_en !== 1'b0) en_seen = 1'b1;
        end
        n_checks++;
        if (en_seen !== 1'b0) begin n_fail++; $display("FAIL unhomed_motor: got motor_en seen 1 want never"); end
        home_at(8'd0, ok);
        n_checks++;
        if (ok !== 1'b1 || flags !== 5'b00110) begin
            n_fail++; $display("FAIL rehome_from_fault: got ok %b flags %b want ok 1 flags 00110", ok, flags);
        end
        bus.target   = 8'd50;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        bus.cmd_home = 1'b1;
        tick;
        bus.cmd_home = 1'b0;
        n_checks++;
        if (flags !== 5'b11010 || bus.motor_dir !== 1'b1) begin
            n_fail++; $display("FAIL busy_ignore_home: got %b dir %b want 11010 dir 1", flags, bus.motor_dir);
        end
        bus.abort    = 1'b1;
        bus.cmd_move = 1'b1;
        bus.target   = 8'd60;
        tick;
        bus.abort    = 1'b0;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b00010) begin n_fail++; $display("FAIL abort_idle: got %b want 00010", flags); end
        tick;
        n_checks++;
        if (flags !== 5'b00010) begin n_fail++; $display("FAIL abort_no_done: got %b want 00010", flags); end
    endtask

    task automatic test_overshoot;
        bus.count    = 8'd0;
        bus.target   = 8'd20;
        bus.cmd_move = 1'b1;
        tick;
        bus.cmd_move = 1'b0;
        n_checks++;
        if (flags !== 5'b11010 || bus.motor_dir !== 1'b1) begin
            n_fail++; $display("FAIL over_start: got %b dir %b want 11010 dir 1", flags, bus.motor_dir);
        end
        for (int k = 0; k < 4; k++) begin
            bus.count = 8'd20;
            tick;
            n_checks++;
            if (flags !== 5'b01010) begin n_fail++; $display("FAIL over_settle_%0d: got %b want 01010", k, flags); end
            bus.count = 8'd24;
            repeat (4) tick;
            if (k < 3) begin
                n_checks++;
                if (flags !== 5'b11010 || bus.motor_dir !== 1'b0) begin
                    n_fail++; $display("FAIL over_remove_%0d: got %b dir %b want 11010 dir 0", k, flags, bus.motor_dir);
                end
            end
        end
        n_checks++;
        if (flags !== 5'b00011) begin n_fail++; $display("FAIL over_fault: got %b want 00011", flags); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        clk          = 1'b0;
        rst_n        = 1'b0;
        bus.count    = 8'd37;
        bus.home_sw  = 1'b0;
        bus.cmd_home = 1'b0;
        bus.cmd_move = 1'b0;
        bus.target   = 8'd0;
        bus.abort    = 1'b0;
        test_reset;
        test_homing;
        test_move_up;
        test_wrap;
        test_stall;
        test_unhomed_abort;
        test_overshoot;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got no completion by 100000 ns, want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/encoder_move_ctrl.md
Name: encoder_move_ctrl

Overview:
Position sequencer for one motor axis fed by the quadrature_decode count.
- Runs a homing sequence against a home switch and latches a software zero offset; the decoder itself is never cleared.
- Drives motor enable and direction to reach a commanded target within a deadband, with settle and stall-fault supervision.
- Sits between the command/register logic and the motor driver pins, alongside the decoder instance.

Parameters:
width, 8, count/position/target width; must match decoder width
DEADBAND, 1, max |target - position| accepted as arrived
STALL_CYCLES, 16, clocks without a count change while motor_en=1 before fault
SETTLE_CYCLES, 4, clocks motor held off before position is sampled

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
count  in  width  raw decoder count, free-running, wraps mod 2^width
home_sw  in  1  raw home switch, active high; synchronized internally (2 flops)
cmd_home  in  1  one-cycle request to start homing
cmd_move  in  1  one-cycle request to move to target
target  in  width  move destination in homed coordinates; sampled on accepted cmd_move
abort  in  1  stop immediately, return to IDLE
motor_en  out  1  motor drive enable
motor_dir  out  1  1 = drive toward increasing count, 0 = decreasing
position  out  width  count - home_offset, mod 2^width, combinational from count
busy  out  1  high in any state except IDLE and FAULT
done  out  1  one-cycle pulse on successful home or move completion
homed  out  1  home offset valid
fault  out  1  sticky until the next accepted command or reset

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, motor_en=0, motor_dir=0, done=0, homed=0, fault=0, home_offset=0, all counters=0, sync flops=0.
- Signed distance d = target_q - position, computed in width bits two's complement. Moves take the short way round the wrap.
- States:
  - IDLE: motor off. abort takes precedence, then cmd_home, then cmd_move (same-cycle tie).
    - cmd_home -> HOME_SEEK; clears fault.
    - cmd_move with homed=1: latch target_q, clear fault. If |d|<=DEADBAND, pulse done next cycle and stay in IDLE; else -> MOVE.
    - cmd_move with homed=0: -> FAULT.
  - HOME_SEEK: motor_en=1, motor_dir=0. On synchronized home_sw=1 -> HOME_SETTLE with motor_en=0 in the same transition cycle.
  - HOME_SETTLE: motor off for SETTLE_CYCLES clocks. Then home_offset<=count, homed<=1, done pulse -> IDLE.
  - MOVE: motor_en=1, motor_dir = (d>0), re-evaluated every cycle. When |d|<=DEADBAND -> SETTLE with motor_en=0.
  - SETTLE: motor off for SETTLE_CYCLES clocks, then recheck d. Within deadband: done pulse -> IDLE. Else -> MOVE. At most 3 re-entries per command, then -> FAULT.
  - FAULT: motor off, fault=1. Leaves only on an accepted cmd_home or cmd_move (same rules as IDLE, with homed preserved).
- Stall: a counter resets on any change of count vs its previous-cycle value, or when motor_en=0. Reaching STALL_CYCLES while motor_en=1 -> FAULT.
- abort in any state: next cycle state=IDLE, motor_en=0, no done. fault and homed are unchanged.
- cmd_home/cmd_move while busy: ignored. target changes while busy: ignored.
- cmd_home while homed: rehomes; homed stays 1 until the new offset is latched.
- Reset mid-operation: immediate return to reset values, including homed=0.
- motor_en, motor_dir, done, busy, homed and fault are registered outputs.

Decomposition:
- Shared package: state encoding constants, and the default values of DEADBAND, SETTLE_CYCLES and STALL_CYCLES.
- One natural sub-module: stall_monitor (count-change detector plus saturating stall counter, outputs stall).
- The 2-flop synchronizer is inline.

Test Plan:
- Homing: reset, pulse cmd_home, hold count=37, raise home_sw at cycle 10 -> motor_en=1/dir=0 until sync, then motor off; done after 4 settle cycles; homed=1, home_offset=37, position=0.
- Move up: homed at 37, target=20, pulse cmd_move, bench increments count each 4 cycles -> dir=1. At count=56 (position 19) motor_en drops; done after settle; busy low.
- Wrap: homed at offset 0, count=250, target=5 -> d=+11, dir=1. Count steps 250..255,0..4 -> stops at position 4, done asserted.
- Stall: homed, target=100, count held constant -> fault=1 and motor_en=0 exactly 16 cycles after motor_en rose. Then cmd_move with reachable target clears fault.
- Unhomed move: after reset, cmd_move -> fault=1, motor_en never asserted. cmd_move and abort in the same cycle during MOVE -> IDLE, no done.
- Overshoot: target=20, count jumps to position 24 during settle -> returns to MOVE with dir=0; a fourth overshoot -> FAULT.
